custom_apb_multitimer: RTL

- Parametrised successor to the single millisecond APB timer.
- Contains a programmable shared tick prescaler, a free-running tick counter, and NUM_CH independent down-counting channels.
- Each channel runs in one-shot or periodic mode and raises a per-channel interrupt.
- Sits on the APB peripheral bus beside the other custom APB slaves. Firmware uses it for profiling and periodic events.

---
 rtl/custom_apb_multitimer.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/custom_apb_multitimer.sv
// ---------------------------------------------------------------------------
// custom_apb_multitimer
//   APB slave with a shared tick prescaler, a free-running tick counter and
//   NUM_CH independent down-counting channels. Each channel runs one-shot or
//   periodic and raises a level interrupt (flag AND irq_en).
//
// Ports
//   pclk, preset         clock, asynchronous active-high reset
//   psel, penable,       APB request; paddr is a byte address and its
//   pwrite, paddr,       two low bits are ignored
//   pwdata
//   prdata               read data, registered in the setup phase
//   pready               always 1 (zero wait states)
//   pslverr              1 during the access phase of an unmapped access
//   tick_cnt             mirror of the TICK_CNT register
//   irq, irq_any         per-channel interrupts and their OR
//
// Register map
//   0x000 GCTRL     bit0 presc_en
//   0x004 PRESCALE  tick every PRESCALE+1 cycles
//   0x008 TICK_CNT  read-only; writing 0x5EA clears it
//   0x100+0x10*n    channel n: +0 CTRL {irq_en,periodic,en}, +4 LOAD,
//                   +8 VALUE (read-only), +C STATUS bit0 flag (W1C)
// ---------------------------------------------------------------------------
module custom_apb_multitimer #(
    parameter int ADDRWIDTH = 12,
    parameter int CLK_FREQ  = 50000000,
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 psel,
    input  logic [ADDRWIDTH-1:0] paddr,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic [31:0]          tick_cnt,
    output logic [NUM_CH-1:0]    irq,
    output logic                 irq_any
);

    localparam logic [31:0] PRESCALE_RST = 32'(CLK_FREQ / 1000 - 1);
    localparam logic [31:0] TICK_CLR_KEY = 32'h0000_05EA;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // Global state
    logic        presc_en_q;
    logic [31:0] prescale_q;
    logic [31:0] pre_cnt_q,  pre_cnt_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [31:0] prdata_q;
    logic        pslverr_q;
    logic        tick;

    // Channel state
    ch_state_t            state_q    [NUM_CH];
    logic                 periodic_q [NUM_CH];
    logic                 irq_en_q   [NUM_CH];
    logic                 flag_q     [NUM_CH];
    logic [CNT_WIDTH-1:0] load_q     [NUM_CH];
    logic [CNT_WIDTH-1:0] value_q    [NUM_CH];

    // Per-channel write strobes and expiry
    logic ctrl_wr [NUM_CH];
    logic stop_wr [NUM_CH];
    logic load_wr [NUM_CH];
    logic w1c     [NUM_CH];
    logic expire  [NUM_CH];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0] addr;
    logic        unused_paddr;
    logic        hit_gctrl, hit_presc, hit_tick, is_ch;
    logic [3:0]  ch_idx;
    logic [1:0]  ch_reg;
    logic        mapped;
    logic [31:0] rd_data;
    logic        wr_ok, wr_ch;
    logic        wr_gctrl, wr_presc, wr_tick_clr;

    assign addr         = 32'({paddr[ADDRWIDTH-1:2], 2'b00});
    assign unused_paddr = &{1'b0, paddr[1:0]};
    assign hit_gctrl    = (addr == 32'h000);
    assign hit_presc    = (addr == 32'h004);
    assign hit_tick     = (addr == 32'h008);
    assign is_ch        = (addr[31:8] == 24'h1);
    assign ch_idx       = addr[7:4];
    assign ch_reg       = addr[3:2];

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        rd_data = '0;
        mapped  = 1'b0;
        if (hit_gctrl) begin
            mapped  = 1'b1;
            rd_data = {31'b0, presc_en_q};
        end else if (hit_presc) begin
            mapped  = 1'b1;
            rd_data = prescale_q;
        end else if (hit_tick) begin
            mapped  = 1'b1;
            rd_data = tick_cnt_q;
        end else if (is_ch) begin
            // Channel indices at or above NUM_CH fall through as unmapped.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx == 4'(i)) begin
                    mapped = 1'b1;
                    case (ch_reg)
                        2'd0:    rd_data = {29'b0, irq_en_q[i], periodic_q[i],
                                            state_q[i] == CH_RUN};
                        2'd1:    rd_data = 32'(load_q[i]);
                        2'd2:    rd_data = 32'(value_q[i]);
                        default: rd_data = {31'b0, flag_q[i]};
                    endcase
                end
            end
        end
    end

    assign wr_ok       = psel & penable & pwrite & mapped;
    assign wr_ch       = wr_ok & is_ch;
    assign wr_gctrl    = wr_ok & hit_gctrl;
    assign wr_presc    = wr_ok & hit_presc;
    assign wr_tick_clr = wr_ok & hit_tick & (pwdata == TICK_CLR_KEY);

    // ------------------------------------------------------------------
    // Prescaler and tick counter
    // ------------------------------------------------------------------
    assign tick = presc_en_q & (pre_cnt_q == prescale_q);

    always_comb begin
        pre_cnt_d = pre_cnt_q + 32'd1;
        if (wr_presc || !presc_en_q || tick) pre_cnt_d = '0;

        // A clear write beats a coincident tick.
        tick_cnt_d = tick_cnt_q;
        if (wr_tick_clr)  tick_cnt_d = '0;
        else if (tick)    tick_cnt_d = tick_cnt_q + 32'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values; combinational blocks use blocking ones.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            presc_en_q <= 1'b1;
            prescale_q <= PRESCALE_RST;
            pre_cnt_q  <= '0;
            tick_cnt_q <= '0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            if (wr_gctrl) presc_en_q <= pwdata[0];
            if (wr_presc) prescale_q <= pwdata;
            // Capture in the setup phase so data and error are stable for
            // the whole access phase; the error drops after the access edge.
            if (psel && !penable) begin
                prdata_q  <= rd_data;
                pslverr_q <= ~mapped;
            end else begin
                pslverr_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ctrl_wr[i] = wr_ch && (ch_idx == 4'(i)) && (ch_reg == 2'd0);
            stop_wr[i] = ctrl_wr[i] && !pwdata[0];
            load_wr[i] = wr_ch && (ch_idx == 4'(i)) && (ch_reg == 2'd1);
            w1c[i]     = wr_ch && (ch_idx == 4'(i)) && (ch_reg == 2'd3) && pwdata[0];
            // A disabling write on the same edge pre-empts expiry.
            expire[i]  = (state_q[i] == CH_RUN) && tick && (value_q[i] == '0)
                         && !stop_wr[i];
        end
    end

    // NOTE: the per-channel arrays are a handful of flops, not a RAM, so
    // they are reset like any other register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]    <= CH_IDLE;
                periodic_q[i] <= 1'b0;
                irq_en_q[i]   <= 1'b0;
                flag_q[i]     <= 1'b0;
                load_q[i]     <= '0;
                value_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ctrl_wr[i]) begin
                    periodic_q[i] <= pwdata[1];
                    irq_en_q[i]   <= pwdata[2];
                end
                // LOAD only takes effect at the next enable or reload.
                if (load_wr[i]) load_q[i] <= pwdata[CNT_WIDTH-1:0];

                // Setting beats a coincident write-1-to-clear.
                if (expire[i])   flag_q[i] <= 1'b1;
                else if (w1c[i]) flag_q[i] <= 1'b0;

                case (state_q[i])
                    CH_IDLE: begin
                        if (ctrl_wr[i] && pwdata[0]) begin
                            state_q[i] <= CH_RUN;
                            value_q[i] <= load_q[i];
                        end
                    end
                    CH_RUN: begin
                        if (stop_wr[i]) begin
                            state_q[i] <= CH_IDLE;
                        end else if (tick) begin
                            if (value_q[i] != '0)  value_q[i] <= value_q[i] - CNT_WIDTH'(1);
                            else if (periodic_q[i]) value_q[i] <= load_q[i];
                            else                    state_q[i] <= CH_IDLE;
                        end
                    end
                    default: state_q[i] <= CH_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        irq = '0;
        for (int i = 0; i < NUM_CH; i++) irq[i] = flag_q[i] & irq_en_q[i];
    end

    assign irq_any  = |irq;
    assign prdata   = prdata_q;
    assign pready   = 1'b1;
    assign pslverr  = pslverr_q;
    assign tick_cnt = tick_cnt_q;

endmodule
